// File: rtl/emg_mux_iir_if.sv
// Frame/coefficient/output bundle between the EMG filter and its
// neighbours. The master drives start, spike counts and coefficient
// writes. The slave (the filter) returns status and the packed EMG outputs.
interface emg_mux_iir_if #(
    parameter int unsigned NCH = 8
);
    localparam int unsigned ChW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                 start;
    logic [NCH*32-1:0]    i_spike_cnt;
    logic                 coef_we;
    logic [2:0]           coef_sel;
    logic [ChW-1:0]       coef_chan;
    logic [31:0]          coef_wdata;
    logic                 busy;
    logic                 done;
    logic                 overrun;
    logic [NCH*32-1:0]    f_total_emg_out;

    modport master (
        output start, i_spike_cnt, coef_we, coef_sel, coef_chan, coef_wdata,
        input  busy, done, overrun, f_total_emg_out
    );

    modport slave (
        input  start, i_spike_cnt, coef_we, coef_sel, coef_chan, coef_wdata,
        output busy, done, overrun, f_total_emg_out
    );
endinterface

// File: rtl/emg_mux_iir.sv
// Time-multiplexed recursive EMG filter. One float multiplier, one adder and
// one subtractor are shared by all NCH channels. Each channel takes 5 tap
// cycles plus 1 write-back cycle.
// Optional macro EMG_PER_CHAN_COEF_EN gives each channel its own coefficient
// set, addressed by coef_chan. Without it, one shared set is used.
// Float units flush subnormal inputs and results to signed zero.
module emg_mux_iir #(
    parameter int unsigned NCH = 8
) (
    input  logic         clk,
    input  logic         reset,
    emg_mux_iir_if.slave bus
);
    localparam int unsigned ChW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StIdle, StTap, StWr, StDone} state_e;

    // Round to nearest even and pack. An exponent that is out of range
    // flushes to zero or saturates to infinity.
    function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e,
                                               input logic [22:0] m, input logic g,
                                               input logic st);
        logic [32:0] t;
        t = {e, m} + 33'(g & (st | m[0]));
        if ($signed(t[32:23]) <= 0)   return {s, 31'b0};
        if ($signed(t[32:23]) >= 255) return {s, 8'hff, 23'b0};
        return {s, t[30:0]};
    endfunction

    function automatic logic [31:0] i2f(input logic [31:0] v);
        logic [4:0]  p;
        logic [31:0] m;
        p = '0;
        for (int i = 0; i < 32; i++) if (v[i]) p = 5'(i);
        m = v << (5'd31 - p);
        if (v == '0) return '0;
        return {1'b0, 8'd127 + {3'b0, p}, m[30:8]} + {31'b0, m[7] & ((|m[6:0]) | m[8])};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [47:0]       p;
        logic signed [9:0] e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0)   return {s, 31'b0};
        if (a[30:23] == 8'hff || b[30:23] == 8'hff) return {s, 8'hff, 23'b0};
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = $signed({2'b0, a[30:23]}) + $signed({2'b0, b[30:23]}) - 10'sd127;
        if (p[47]) return round_pack(s, e + 10'sd1, p[46:24], p[23], |p[22:0]);
        return round_pack(s, e, p[45:23], p[22], |p[21:0]);
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       x, y;
        logic [7:0]        d;
        logic [26:0]       mx, my, n;
        logic [27:0]       sum;
        logic signed [9:0] e;
        logic [4:0]        lz;
        if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? {a[31] & b[31], 31'b0} : b;
        if (b[30:23] == 8'd0)  return a;
        if (a[30:23] == 8'hff) return a;
        if (b[30:23] == 8'hff) return b;
        if (a[30:0] < b[30:0]) begin x = b; y = a; end
        else begin x = a; y = b; end
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b0};
        my = {1'b1, y[22:0], 3'b0};
        // Alignment shift. The bits shifted out collapse into a sticky LSB.
        if (d > 8'd26) my = 27'd1;
        else my = (my >> d) | {26'b0, |(my & ~({27{1'b1}} << d))};
        e = $signed({2'b0, x[30:23]});
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, my};
            if (sum[27]) begin
                n = sum[27:1] | {26'b0, sum[0]};
                e = e + 10'sd1;
            end else begin
                n = sum[26:0];
            end
        end else begin
            n = mx - my;
            if (n == '0) return '0;
            lz = '0;
            for (int i = 0; i < 27; i++) if (n[i]) lz = 5'(26 - i);
            n = n << lz;
            e = e - $signed({5'b0, lz});
        end
        return round_pack(x[31], e, n[25:3], n[2], |n[1:0]);
    endfunction

    function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
        return fadd(a, {~b[31], b[30:0]});
    endfunction

    state_e         state_q, state_d;
    logic [2:0]     tap_q, tap_d;
    logic [ChW-1:0] chan_q, chan_d;
    logic [31:0]    acc_q, acc_d;
    logic           overrun_q, overrun_d;
    logic [31:0]    cnt_q [NCH], cnt_d [NCH];
    logic [31:0]    x1_q [NCH], x1_d [NCH], x2_q [NCH], x2_d [NCH];
    logic [31:0]    y1_q [NCH], y1_d [NCH], y2_q [NCH], y2_d [NCH], y3_q [NCH], y3_d [NCH];
    logic [31:0]    out_q [NCH], out_d [NCH];
    logic           busy, accept;
    logic [31:0]    coef, opnd, prod, sum, dif;

    assign busy   = (state_q == StTap) || (state_q == StWr);
    assign accept = bus.start && !busy;

`ifdef EMG_PER_CHAN_COEF_EN
    logic [4:0][31:0] sh_q [NCH], sh_d [NCH], act_q [NCH], act_d [NCH];
    logic             coef_ok;
    assign coef_ok = (bus.coef_sel <= 3'd4) && ({{(32-ChW){1'b0}}, bus.coef_chan} < NCH);

    // Shadow writes. Commit shadow to active (including same-cycle write) on accept.
    always_comb begin
        sh_d  = sh_q;
        act_d = act_q;
        if (bus.coef_we && coef_ok) sh_d[bus.coef_chan][bus.coef_sel] = bus.coef_wdata;
        if (accept) act_d = sh_d;
    end
    assign coef = act_q[chan_q][tap_q];

    // Per-channel coefficient registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q  <= '{default: '0};
            act_q <= '{default: '0};
        end else begin
            sh_q  <= sh_d;
            act_q <= act_d;
        end
    end
`else
    logic [4:0][31:0] sh_q, sh_d, act_q, act_d;
    logic             unused_chan;
    assign unused_chan = ^bus.coef_chan;

    // Shadow writes. Commit shadow to active (including same-cycle write) on accept.
    always_comb begin
        sh_d  = sh_q;
        act_d = act_q;
        if (bus.coef_we && bus.coef_sel <= 3'd4) sh_d[bus.coef_sel] = bus.coef_wdata;
        if (accept) act_d = sh_d;
    end
    assign coef = act_q[tap_q];

    // Shared coefficient registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q  <= '0;
            act_q <= '0;
        end else begin
            sh_q  <= sh_d;
            act_q <= act_d;
        end
    end
`endif

    // Tap operand for the current channel.
    always_comb begin
        opnd = '0;
        unique case (tap_q)
            3'd0:    opnd = x1_q[chan_q];
            3'd1:    opnd = x2_q[chan_q];
            3'd2:    opnd = y1_q[chan_q];
            3'd3:    opnd = y2_q[chan_q];
            default: opnd = y3_q[chan_q];
        endcase
    end

    assign prod = fmul(coef, opnd);
    assign sum  = fadd(acc_q, prod);
    assign dif  = fsub(acc_q, prod);

    // Frame sequencer plus accumulator and history next-state.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        chan_d    = chan_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        x1_d      = x1_q;
        x2_d      = x2_q;
        y1_d      = y1_q;
        y2_d      = y2_q;
        y3_d      = y3_q;
        out_d     = out_q;
        overrun_d = overrun_q | (bus.start & busy);
        case (state_q)
            StTap: begin
                acc_d = (tap_q == 3'd0) ? prod : (tap_q == 3'd1) ? sum : dif;
                if (tap_q == 3'd4) state_d = StWr;
                else tap_d = tap_q + 3'd1;
            end
            StWr: begin
                y3_d[chan_q]  = y2_q[chan_q];
                y2_d[chan_q]  = y1_q[chan_q];
                y1_d[chan_q]  = acc_q;
                x2_d[chan_q]  = x1_q[chan_q];
                x1_d[chan_q]  = i2f(cnt_q[chan_q]);
                out_d[chan_q] = acc_q;
                tap_d         = '0;
                if (chan_q == ChW'(NCH - 1)) begin
                    state_d = StDone;
                end else begin
                    chan_d  = chan_q + 1'b1;
                    state_d = StTap;
                end
            end
            default: begin
                state_d = StIdle;
                if (accept) begin
                    state_d = StTap;
                    tap_d   = '0;
                    chan_d  = '0;
                    for (int k = 0; k < NCH; k++) cnt_d[k] = bus.i_spike_cnt[32*k +: 32];
                end
            end
        endcase
    end

    // Status and packed output slots.
    always_comb begin
        bus.busy    = busy;
        bus.done    = (state_q == StDone);
        bus.overrun = overrun_q;
        for (int k = 0; k < NCH; k++) bus.f_total_emg_out[32*k +: 32] = out_q[k];
    end

    // Sequencer, accumulator, history and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            tap_q     <= '0;
            chan_q    <= '0;
            acc_q     <= '0;
            overrun_q <= 1'b0;
            cnt_q     <= '{default: '0};
            x1_q      <= '{default: '0};
            x2_q      <= '{default: '0};
            y1_q      <= '{default: '0};
            y2_q      <= '{default: '0};
            y3_q      <= '{default: '0};
            out_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            chan_q    <= chan_d;
            acc_q     <= acc_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            y3_q      <= y3_d;
            out_q     <= out_d;
        end
    end
endmodule

// File: tb/tb_emg_mux_iir.sv
// Directed bench for emg_mux_iir with NCH=8. Inputs are driven on the
// falling edge, and outputs are sampled on the falling edge.
module tb_emg_mux_iir;
    localparam int unsigned NCH = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0]       snap18;
    logic [NCH*32-1:0] cnt;
    logic [31:0]       exp_rec [4];
    logic [31:0]       exp_ch0;
    int                n_done;

    emg_mux_iir_if #(.NCH(NCH)) bus_if ();

    emg_mux_iir #(.NCH(NCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ch(input int k);
        return bus_if.f_total_emg_out[32*k +: 32];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic write_coef(input logic [2:0] sel, input logic [2:0] chan,
                              input logic [31:0] data);
        bus_if.coef_we    = 1'b1;
        bus_if.coef_sel   = sel;
        bus_if.coef_chan  = chan;
        bus_if.coef_wdata = data;
        @(negedge clk);
        bus_if.coef_we = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Start a frame in the current cycle and wait for done. mid_coef writes
    // b1=2.0 at T+3, and mid_start raises a second start at T+3.
    task automatic run_frame(input logic [NCH*32-1:0] cnts, input bit mid_coef,
                             input bit mid_start);
        int lat;
        lat = 0;
        bus_if.i_spike_cnt = cnts;
        bus_if.start       = 1'b1;
        for (int cyc = 1; cyc <= 100 && lat == 0; cyc++) begin
            @(negedge clk);
            bus_if.start   = 1'b0;
            bus_if.coef_we = 1'b0;
            if (cyc == 1) check_eq("busy_after_start", {31'b0, bus_if.busy}, 32'd1);
            if (cyc == 3 && mid_start) bus_if.start = 1'b1;
            if (cyc == 3 && mid_coef) begin
                bus_if.coef_we    = 1'b1;
                bus_if.coef_sel   = 3'd0;
                bus_if.coef_chan  = 3'd0;
                bus_if.coef_wdata = 32'h40000000;
            end
            if (cyc == 5 && mid_start) begin
                check_eq("overrun_set", {31'b0, bus_if.overrun}, 32'd1);
                check_eq("busy_after_ovr", {31'b0, bus_if.busy}, 32'd1);
            end
            if (cyc == 18) snap18 = ch(2);
            if (bus_if.done) begin
                lat = cyc;
                check_eq("busy_in_done", {31'b0, bus_if.busy}, 32'd0);
            end
        end
        check_eq("done_latency", lat, 32'd49);
    endtask

    initial begin
        reset              = 1'b0;
        bus_if.start       = 1'b0;
        bus_if.i_spike_cnt = '0;
        bus_if.coef_we     = 1'b0;
        bus_if.coef_sel    = '0;
        bus_if.coef_chan   = '0;
        bus_if.coef_wdata  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'b0, bus_if.busy}, 32'd0);
        check_eq("rst_done", {31'b0, bus_if.done}, 32'd0);
        check_eq("rst_overrun", {31'b0, bus_if.overrun}, 32'd0);
        check_eq("rst_out", {31'b0, |bus_if.f_total_emg_out}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_busy", {31'b0, bus_if.busy}, 32'd0);
        check_eq("idle_done", {31'b0, bus_if.done}, 32'd0);

        // Zero coefficients keep every output at 0.0.
        run_frame('0, 1'b0, 1'b0);
        check_eq("zero_coef_out", {31'b0, |bus_if.f_total_emg_out}, 32'd0);
        @(negedge clk);
        check_eq("done_one_cycle", {31'b0, bus_if.done}, 32'd0);

        // Delay path: b1=1.0, so the output is the previous frame's count.
        write_coef(3'd0, 3'd0, 32'h3F800000);
        cnt = '0;
        cnt[31:0] = 32'd5;
        run_frame(cnt, 1'b0, 1'b0);
        check_eq("delay_f1", ch(0), 32'h00000000);
        @(negedge clk);
        run_frame('0, 1'b0, 1'b0);
        check_eq("delay_f2", ch(0), 32'h40A00000);
        @(negedge clk);

        // Recursion on ch2: a1=-0.5. The sel=5 write must be dropped.
        write_coef(3'd2, 3'd0, 32'hBF000000);
        write_coef(3'd5, 3'd0, 32'h40800000);
        exp_rec = '{32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F000000};
        for (int f = 0; f < 4; f++) begin
            cnt = '0;
            if (f == 0) cnt[95:64] = 32'd2;
            run_frame(cnt, 1'b0, 1'b0);
            check_eq($sformatf("recur_f%0d", f + 1), ch(2), exp_rec[f]);
            check_eq($sformatf("recur_ch1_f%0d", f + 1), ch(1), 32'h00000000);
            if (f == 2) check_eq("slot_hold_before_wr", snap18, 32'h40000000);
            @(negedge clk);
        end

        // Commit atomicity, overrun and back-to-back frames.
        pulse_reset();
        check_eq("rst2_out", {31'b0, |bus_if.f_total_emg_out}, 32'd0);
        write_coef(3'd0, 3'd0, 32'h3F800000);
        cnt = '0;
        cnt[31:0] = 32'd3;
        run_frame(cnt, 1'b0, 1'b0);
        check_eq("commit_f1", ch(0), 32'h00000000);
        @(negedge clk);
        run_frame(cnt, 1'b1, 1'b1);
        check_eq("commit_old_b1", ch(0), 32'h40400000);
        @(negedge clk);
        run_frame('0, 1'b0, 1'b0);
        check_eq("commit_new_b1", ch(0), 32'h40C00000);
        run_frame('0, 1'b0, 1'b0);
        check_eq("b2b_out", ch(0), 32'h00000000);
        check_eq("overrun_sticky", {31'b0, bus_if.overrun}, 32'd1);
        @(negedge clk);

        // Coefficient sets: b1=2.0 on ch0 and 3.0 on ch1.
        pulse_reset();
        check_eq("rst3_overrun", {31'b0, bus_if.overrun}, 32'd0);
        write_coef(3'd0, 3'd0, 32'h40000000);
        write_coef(3'd0, 3'd1, 32'h40400000);
        cnt = '0;
        cnt[31:0]  = 32'd1;
        cnt[63:32] = 32'd1;
        run_frame(cnt, 1'b0, 1'b0);
        @(negedge clk);
        run_frame('0, 1'b0, 1'b0);
`ifdef EMG_PER_CHAN_COEF_EN
        exp_ch0 = 32'h40000000;
`else
        exp_ch0 = 32'h40400000;
`endif
        check_eq("coefset_ch0", ch(0), exp_ch0);
        check_eq("coefset_ch1", ch(1), 32'h40400000);
        @(negedge clk);

        // Reset mid-frame aborts the frame and suppresses done.
        bus_if.i_spike_cnt = '0;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("abort_busy", {31'b0, bus_if.busy}, 32'd0);
        check_eq("abort_out", ch(1), 32'h00000000);
        @(negedge clk);
        reset = 1'b1;
        n_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus_if.done) n_done++;
        end
        check_eq("abort_no_done", n_done, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/emg_mux_iir.md
# emg_mux_iir

Time-multiplexed, multi-channel successor to the single-channel floating-point recursive EMG filter.
- For each of `NCH` motor-unit pools, applies y[n] = b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2] − a3·y[n-3] to an integer spike count.
- One shared combinational `mult`, one `add` and one `sub` (IEEE-754 single) are time-shared across all channels.
- Sits between the spike-count aggregators and the EMG output/readout logic, and is triggered once per model time step.

## Interface
- `NCH`, 8, number of channels (≥1); channel index width is clog2(NCH), minimum 1.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `start` in 1: one-cycle frame request; accepted only when `busy`=0.
- `i_spike_cnt` in NCH·32: packed unsigned spike counts; channel k occupies [32k+31:32k].
- `coef_we` in 1: coefficient write strobe.
- `coef_sel` in 3: tap select; 0=b1, 1=b2, 2=a1, 3=a2, 4=a3; values 5–7 are ignored.
- `coef_chan` in clog2(NCH): target channel; used only with `EMG_PER_CHAN_COEF_EN`.
- `coef_wdata` in 32: float coefficient.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse when all channels have been updated.
- `overrun` out 1: sticky; set when `start` arrives while `busy`=1.
- `f_total_emg_out` out NCH·32: packed float EMG; channel k occupies [32k+31:32k].

## Operation
Coefficients:
- Writes land in shadow registers on the cycle `coef_we`=1.
- Shadow registers are copied to active registers only at frame acceptance, so a frame never uses a mixed coefficient set.

Frame acceptance (`start`=1 and `busy`=0):
- All `i_spike_cnt` channels are latched, then converted via `int_to_float`.
- Active coefficients are committed.
- `busy` goes to 1.

FSM states: IDLE → TAP (5 cycles, tap index 0..4) → WR (1 cycle) → next channel TAP, or DONE after channel NCH−1 → IDLE.

Per-channel accumulation order is fixed and must be matched bit-exactly by the model:
- TAP0: acc = b1·x1
- TAP1: acc = acc + b2·x2
- TAP2: acc = acc − a1·y1
- TAP3: acc = acc − a2·y2
- TAP4: acc = acc − a3·y3

WR for channel k:
- y3←y2, y2←y1, y1←acc.
- x2←x1, x1←latched float count of channel k.
- Output slot k←acc.

Other rules:
- History state (x1, x2, y1, y2, y3) is kept per channel in register arrays.
- Other channels' output slots hold their value during the frame.
- `start` while `busy`=1 is ignored and sets `overrun`; only reset clears `overrun`.
- `coef_sel` > 4 and, with the macro, `coef_chan` ≥ NCH are dropped silently.
- No NaN/Inf handling beyond what `mult`/`add`/`sub` produce.

Reset values: all outputs 0, including `f_total_emg_out`, `busy`, `done` and `overrun`. All history, shadow and active coefficients are also 0.0, so the output stays 0.0 until coefficients are loaded.

Reset asserted mid-frame: the frame is aborted, every register returns to its reset value, and no `done` is issued.

## Timing
- `start` sampled high in cycle T (with `busy`=0) → `busy`=1 from T+1.
- Channel k TAP cycles: T+6k+1 to T+6k+5. WR cycle: T+6k+6. Output slot k is visible from T+6k+7.
- `done`=1 and `busy`=0 in cycle T+6·NCH+1.
- A `start` in the `done` cycle is accepted, giving back-to-back frames with a period of 6·NCH+1 cycles.
- A coefficient write in the same cycle as an accepted `start` is included in that frame's commit.

## Configuration
`EMG_PER_CHAN_COEF_EN`:
- Defined: NCH independent shadow/active coefficient sets, addressed by `coef_chan`; channel k's taps use set k.
- Undefined: a single shared set used by all channels; `coef_chan` is ignored and no per-channel coefficient storage is built.

## Test plan
- Reset/idle: release reset, no `start` → all outputs 0 and `f_total_emg_out` all zeros; first `start` → `done` exactly at T+6·NCH+1.
- Delay path: b1=0x3F800000, others 0; ch0 count 5 on frame 1, 0 on frame 2 → ch0 reads 0x00000000 after frame 1 and 0x40A00000 (5.0) after frame 2.
- Recursion: b1=1.0, a1=0xBF000000 (−0.5); ch2 count 2 on frame 1, then 0 → ch2 after frames 1–4 reads 0.0, 2.0, 1.0, 0.5. Other channels with count 0 stay 0.0.
- Commit atomicity: set b1=2.0 via `coef_we` mid-frame while `busy`=1 → the current frame uses the old b1; the next frame uses 2.0.
- Overrun/back-to-back: `start` at T+3 → ignored, `overrun`=1 and stays 1; `start` in the `done` cycle → accepted, `busy` stays high with no gap.
- Macro: with `EMG_PER_CHAN_COEF_EN`, b1 = 2.0 on ch0 and 3.0 on ch1, count 1 on both → frame 2 gives 2.0 and 3.0. Without the macro, both channels give 3.0 (the last write).
